// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package  : alu_pkg                                               |
// | Brief    : Shared ALU width and serial-adder state encodings.    |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : full_adder                                            |
// | Brief    : One-bit combinational full adder.                     |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic carry_i,
  output logic sum_o,
  output logic carry_o
);

  logic w_half;

  assign w_half  = a_i ^ b_i;
  assign sum_o   = w_half ^ carry_i;
  assign carry_o = (a_i & b_i) | (carry_i & w_half);

endmodule
`default_nettype wire

// File: rtl/bit_serial_adder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : bit_serial_adder                                      |
// | Brief    : LSB-first serial add/subtract with start/busy/done.   |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module bit_serial_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             overflow_o
);

  localparam int                 CNT_W      = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]   C_LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_res_sr;
  logic               r_carry_q;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry;
  logic               r_zero;
  logic               r_overflow;

  logic               w_sum;
  logic               w_cout;
  logic [WIDTH-1:0]   w_res_next;

  full_adder u_full_adder (
    .a_i     (r_a_sr[0]),
    .b_i     (r_b_sr[0]),
    .carry_i (r_carry_q),
    .sum_o   (w_sum),
    .carry_o (w_cout)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 lands at index 0.
  assign w_res_next = (r_res_sr >> 1) | (WIDTH'(w_sum) << (WIDTH - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_a_sr     <= '0;
      r_b_sr     <= '0;
      r_res_sr   <= '0;
      r_carry_q  <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            r_a_sr    <= a_i;
            r_b_sr    <= sub_i ? ~b_i : b_i;
            r_carry_q <= sub_i;
            r_cnt     <= '0;
            r_res_sr  <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_a_sr    <= r_a_sr >> 1;
          r_b_sr    <= r_b_sr >> 1;
          r_res_sr  <= w_res_next;
          r_carry_q <= w_cout;
          if (r_cnt == C_LAST_BIT) begin
            // r_carry_q here is the carry into the MSB position.
            r_result   <= w_res_next;
            r_carry    <= w_cout;
            r_zero     <= (w_res_next == '0);
            r_overflow <= r_carry_q ^ w_cout;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign result_o   = r_result;
  assign carry_o    = r_carry;
  assign zero_o     = r_zero;
  assign overflow_o = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_adder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_bit_serial_adder                                   |
// | Brief    : Vector table, corner sequences and random vs. model.  |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_bit_serial_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sub;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       carry;
  logic       zero;
  logic       overflow;

  int n_tests;
  int n_fail;

  bit_serial_adder #(.WIDTH(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .sub_i      (sub),
    .a_i        (a_in),
    .b_i        (b_in),
    .busy_o     (busy),
    .done_o     (done),
    .result_o   (result),
    .carry_o    (carry),
    .zero_o     (zero),
    .overflow_o (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       s;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] r;
    logic       c;
    logic       z;
    logic       v;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model from plain integer arithmetic on the operand values.
  task automatic model(input logic s, input int a, input int b,
                       output int r, output int c, output int z, output int v);
    int sa;
    int sb;
    int t;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    if (s) begin
      r = (a - b + 16) % 16;
      c = (a >= b) ? 1 : 0;
      t = sa - sb;
    end else begin
      r = (a + b) % 16;
      c = (a + b > 15) ? 1 : 0;
      t = sa + sb;
    end
    z = (r == 0) ? 1 : 0;
    v = (t < -8 || t > 7) ? 1 : 0;
  endtask

  // Issues one op and returns the number of edges until done_o (accepting edge = 1).
  task automatic run_op(input logic s, input logic [3:0] a, input logic [3:0] b,
                        output int lat);
    @(negedge clk);
    start = 1'b1;
    sub   = s;
    a_in  = a;
    b_in  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    chk("busy_in_run", int'(busy), 1);
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int r, c, z, v;
    int seen;
    logic [3:0] ra, rb;
    logic       rs;

    n_tests = 0;
    n_fail  = 0;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a_in  = '0;
    b_in  = '0;

    vecs[0] = '{1'b0, 4'd3,  4'd5, 4'd8,  1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 4'd15, 4'd1, 4'd0,  1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 4'd0,  4'd0, 4'd0,  1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 4'd5,  4'd3, 4'd2,  1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 4'd3,  4'd5, 4'd14, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 4'd8,  4'd1, 4'd7,  1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 4'd7,  4'd7, 4'd14, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 4'd0,  4'd0, 4'd0,  1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 4'd0,  4'd1, 4'd15, 1'b0, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_flags", int'({carry, zero, overflow}), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("vec%0d_latency", i), lat, 5);
      chk($sformatf("vec%0d_result", i), int'(result), int'(vecs[i].r));
      chk($sformatf("vec%0d_carry", i), int'(carry), int'(vecs[i].c));
      chk($sformatf("vec%0d_zero", i), int'(zero), int'(vecs[i].z));
      chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(vecs[i].v));
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_hold", i), int'(result), int'(vecs[i].r));
      chk($sformatf("vec%0d_done_pulse", i), int'(done), 0);
    end

    // start held through RUN with new operands, still high in DONE.
    @(negedge clk);
    start = 1'b1;
    sub   = 1'b0;
    a_in  = 4'd3;
    b_in  = 4'd5;
    @(posedge clk);
    #1;
    sub  = 1'b1;
    a_in = 4'd9;
    b_in = 4'd9;
    lat  = 1;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("b2b_first_latency", lat, 5);
    chk("b2b_first_result", int'(result), 8);
    chk("b2b_first_ovf", int'(overflow), 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    chk("b2b_second_busy", int'(busy), 1);
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("b2b_second_latency", lat, 5);
    chk("b2b_second_result", int'(result), 0);
    chk("b2b_second_carry", int'(carry), 1);
    chk("b2b_second_zero", int'(zero), 1);

    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      model(rs, int'(ra), int'(rb), r, c, z, v);
      run_op(rs, ra, rb, lat);
      chk("rnd_latency", lat, 5);
      chk($sformatf("rnd_result s=%0d a=%0d b=%0d", rs, ra, rb), int'(result), r);
      chk("rnd_carry", int'(carry), c);
      chk("rnd_zero", int'(zero), z);
      chk("rnd_ovf", int'(overflow), v);
    end

    // Make outputs nonzero before the abort so the reset clear is observable.
    run_op(1'b0, 4'd15, 4'd15, lat);
    chk("pre_abort_result", int'(result), 14);
    @(negedge clk);
    start = 1'b1;
    sub   = 1'b0;
    a_in  = 4'd2;
    b_in  = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_flags", int'({carry, zero, overflow}), 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    chk("abort_no_done", seen, 0);
    run_op(1'b0, 4'd6, 4'd7, lat);
    chk("post_abort_latency", lat, 5);
    chk("post_abort_result", int'(result), 13);
    chk("post_abort_ovf", int'(overflow), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
